zstr_sink: RTL and testbench
============================

ZSTR_SINK -- requirements
Module: zstr_sink

Interface
REQ-001 SHALL have parameter BW, default 1, meaning z_bus width in bits.
REQ-002 SHALL have parameter AW, default 4, meaning capture FIFO address width; DEPTH = 2**AW.
REQ-003 SHALL have parameter SEED, default 16'hACE1, meaning LFSR reset value; nonzero.
REQ-004 z_clk  input  1  system clock; all state on rising edge.
REQ-005 z_rst  input  1  reset, asynchronous, active-high.
REQ-006 z_vld  input  1  transfer valid from source.
REQ-007 z_bus  input  BW  grouped bus signals from source.
REQ-008 z_ack  output  1  transfer acknowledge, registered.
REQ-009 cfg_mode  input  2  ack policy: 0 always, 1 never, 2 periodic, 3 random.
REQ-010 cfg_per  input  8  periodic-mode interval.
REQ-011 r_rd  input  1  capture FIFO pop request.
REQ-012 r_vld  output  1  capture FIFO not empty.
REQ-013 r_dat  output  BW  FIFO head word, show-ahead.
REQ-014 r_cnt  output  AW+1  FIFO occupancy, 0..DEPTH.
REQ-015 cnt_trn  output  32  accepted transfer count.
REQ-016 cnt_stl  output  32  stall cycle count.

Function
REQ-017 Transfer SHALL occur at a rising z_clk edge where z_vld=1 and z_ack=1 (z_trn); z_bus sampled at that edge is pushed into the FIFO.
REQ-018 z_bus SHALL be ignored when z_trn=0, including X/Z values.
REQ-019 z_ack SHALL be a flop; no combinational path from z_vld or z_bus to z_ack.
REQ-020 z_ack next value = policy_next AND (occupancy_next < DEPTH), where occupancy_next accounts for this edge's push and pop.
REQ-021 Mode 0: policy_next = 1 every cycle.
REQ-022 Mode 1: policy_next = 0 every cycle.
REQ-023 Mode 2: 8-bit phase counter counts 0..cfg_per then wraps to 0; policy_next = 1 exactly when the counter's next value is 0; cfg_per=0 behaves as mode 0.
REQ-024 Mode 3: 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, advances every cycle regardless of mode; policy_next = next LFSR bit 0.
REQ-025 Phase counter SHALL reset to 0 on any cfg_mode or cfg_per change.
REQ-026 Pop: r_rd=1 and r_vld=1 at an edge removes the head word; r_rd while empty SHALL be ignored with no state change.
REQ-027 Simultaneous push and pop SHALL leave r_cnt unchanged; at full, a same-edge pop makes z_ack=1 possible next cycle.
REQ-028 Push when full SHALL be impossible by construction; r_cnt never exceeds DEPTH.
REQ-029 r_dat SHALL equal the oldest unpopped word whenever r_vld=1; X permitted when empty.
REQ-030 Pointers SHALL be AW bits wrapping modulo DEPTH; FIFO order preserved across wrap.
REQ-031 cnt_trn increments by 1 per z_trn and wraps at 2**32.
REQ-032 cnt_stl increments by 1 per edge with z_vld=1 and z_ack=0 and wraps at 2**32.

Reset
REQ-033 While z_rst=1: z_ack=0, r_vld=0, r_cnt=0, cnt_trn=0, cnt_stl=0, pointers=0, phase counter=0, LFSR=SEED.
REQ-034 Reset asserted mid-transfer SHALL drop z_ack immediately and discard all FIFO contents; FIFO storage itself need not be cleared.
REQ-035 First edge after reset release SHALL compute z_ack per REQ-020; z_ack may rise no earlier than one cycle after release.

Verification
REQ-036 Mode 0, AW=2, source sends 0x1,0x2,0x3,0x4,0x5 back-to-back, r_rd=0 -> four transfers accepted, z_ack=0 after the fourth, r_cnt=4, cnt_stl counts while 0x5 waits.
REQ-037 From REQ-036 state, pulse r_rd one cycle -> r_dat pops 0x1, z_ack returns 1, 0x5 accepted, FIFO order 0x2,0x3,0x4,0x5.
REQ-038 Mode 2, cfg_per=3, continuous z_vld -> z_ack high exactly 1 cycle in 4, cnt_trn=25 after 100 cycles.
REQ-039 Mode 3, SEED=16'hACE1 -> z_ack sequence matches reference LFSR model bit-exact for 1000 cycles; no transfer lost or duplicated.
REQ-040 Mode 1 with z_vld=1 for 10 cycles -> z_ack=0 throughout, cnt_trn=0, cnt_stl=10.
REQ-041 Assert z_rst with r_cnt=3 and z_vld=1 -> z_ack, r_vld, counters 0 asynchronously; after release, fresh word captured correctly.

Source files
------------

// File: rtl/zstr_if.sv
// Source-to-sink stream handshake: valid from the source, bus payload,
// and a registered acknowledge returned by the sink.
interface zstr_if #(
  parameter int BW = 1
) ();

  logic          z_vld;
  logic [BW-1:0] z_bus;
  logic          z_ack;

  modport master (
    output z_vld,
    output z_bus,
    input  z_ack
  );

  modport slave (
    input  z_vld,
    input  z_bus,
    output z_ack
  );

endinterface

// File: rtl/zstr_sink.sv
// Stream sink with a configurable acknowledge policy (always, never,
// periodic, pseudo-random), a show-ahead capture FIFO for accepted words,
// and free-running transfer/stall counters.
module zstr_sink #(
  parameter int          BW   = 1,
  parameter int          AW   = 4,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic          z_clk,
  input  logic          z_rst,
  zstr_if.slave         zs,
  input  logic [1:0]    cfg_mode,
  input  logic [7:0]    cfg_per,
  input  logic          r_rd,
  output logic          r_vld,
  output logic [BW-1:0] r_dat,
  output logic [AW:0]   r_cnt,
  output logic [31:0]   cnt_trn,
  output logic [31:0]   cnt_stl
);

  localparam int        DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    MODE_ALWAYS   = 2'd0,
    MODE_NEVER    = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_RANDOM   = 2'd3
  } mode_e;

  mode_e         mode;
  logic          z_trn;
  logic          pop;
  logic          stall;
  logic [AW:0]   occ_next;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic [7:0]    phase;
  logic [7:0]    phase_next;
  logic [1:0]    mode_q;
  logic [7:0]    per_q;
  logic          cfg_chg;
  logic          policy_next;
  logic          ack_next;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [BW-1:0] mem [DEPTH];

  assign mode  = mode_e'(cfg_mode);
  assign z_trn = zs.z_vld & zs.z_ack;
  assign stall = zs.z_vld & ~zs.z_ack;
  assign r_vld = (r_cnt != '0);
  assign pop   = r_rd & r_vld;
  assign r_dat = mem[rd_ptr];

  // Next-cycle policy: occupancy after this edge, LFSR step, phase step, and the ack decision.
  always_comb begin
    occ_next    = r_cnt + (AW + 1)'(z_trn) - (AW + 1)'(pop);
    lfsr_next   = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    cfg_chg     = (cfg_mode != mode_q) || (cfg_per != per_q);
    phase_next  = phase + 8'd1;
    policy_next = 1'b0;
    if (cfg_chg || (phase >= cfg_per)) begin
      phase_next = 8'd0;
    end
    case (mode)
      MODE_ALWAYS:   policy_next = 1'b1;
      MODE_NEVER:    policy_next = 1'b0;
      MODE_PERIODIC: policy_next = (phase_next == 8'd0);
      MODE_RANDOM:   policy_next = lfsr_next[0];
      default:       policy_next = 1'b0;
    endcase
    ack_next = policy_next && (occ_next < DEPTH_C);
  end

  // Control state: ack flop, policy generators, FIFO pointers/occupancy and counters.
  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      zs.z_ack <= 1'b0;
      lfsr     <= SEED;
      phase    <= 8'd0;
      mode_q   <= 2'd0;
      per_q    <= 8'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      r_cnt    <= '0;
      cnt_trn  <= 32'd0;
      cnt_stl  <= 32'd0;
    end else begin
      zs.z_ack <= ack_next;
      lfsr     <= lfsr_next;
      phase    <= phase_next;
      mode_q   <= cfg_mode;
      per_q    <= cfg_per;
      r_cnt    <= occ_next;
      if (z_trn) begin
        wr_ptr  <= wr_ptr + AW'(1);
        cnt_trn <= cnt_trn + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (stall) begin
        cnt_stl <= cnt_stl + 32'd1;
      end
    end
  end

  // Capture storage is written only on an accepted transfer and never cleared.
  always_ff @(posedge z_clk) begin
    if (z_trn) begin
      mem[wr_ptr] <= zs.z_bus;
    end
  end

endmodule

// File: tb/tb_zstr_sink.sv
// Self-checking bench for zstr_sink: a behavioural model predicts the ack
// sequence and counters, and a scoreboard queue holds accepted words that
// are compared against the FIFO head whenever it is valid.
module tb_zstr_sink;

  localparam int BW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          z_clk = 1'b0;
  logic          z_rst = 1'b1;
  logic [1:0]    cfg_mode;
  logic [7:0]    cfg_per;
  logic          r_rd;
  logic          r_vld;
  logic [BW-1:0] r_dat;
  logic [AW:0]   r_cnt;
  logic [31:0]   cnt_trn;
  logic [31:0]   cnt_stl;

  zstr_if #(.BW(BW)) zs ();

  zstr_sink #(
    .BW   (BW),
    .AW   (AW),
    .SEED (16'hACE1)
  ) dut (
    .z_clk    (z_clk),
    .z_rst    (z_rst),
    .zs       (zs.slave),
    .cfg_mode (cfg_mode),
    .cfg_per  (cfg_per),
    .r_rd     (r_rd),
    .r_vld    (r_vld),
    .r_dat    (r_dat),
    .r_cnt    (r_cnt),
    .cnt_trn  (cnt_trn),
    .cnt_stl  (cnt_stl)
  );

  // Free-running 100 MHz clock.
  always #5 z_clk = ~z_clk;

  int checks = 0;
  int errors = 0;

  logic          m_ack;
  int            m_cnt;
  logic [31:0]   m_trn;
  logic [31:0]   m_stl;
  logic [15:0]   m_lfsr;
  logic [7:0]    m_phase;
  logic [1:0]    m_mode_q;
  logic [7:0]    m_per_q;
  logic          m_last_trn;
  logic [BW-1:0] sb [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_ack      = 1'b0;
    m_cnt      = 0;
    m_trn      = 32'd0;
    m_stl      = 32'd0;
    m_lfsr     = 16'hACE1;
    m_phase    = 8'd0;
    m_mode_q   = 2'd0;
    m_per_q    = 8'd0;
    m_last_trn = 1'b0;
    sb.delete();
  endtask

  task automatic modelEdge();
    logic        trn;
    logic        pop;
    int          occ;
    logic [15:0] ln;
    logic [7:0]  pn;
    logic        pol;
    trn = zs.z_vld && m_ack;
    pop = r_rd && (m_cnt != 0);
    if (pop) void'(sb.pop_front());
    if (trn) sb.push_back(zs.z_bus);
    occ = m_cnt + (trn ? 1 : 0) - (pop ? 1 : 0);
    ln  = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    if ((cfg_mode != m_mode_q) || (cfg_per != m_per_q)) pn = 8'd0;
    else if (m_phase == cfg_per) pn = 8'd0;
    else pn = m_phase + 8'd1;
    case (cfg_mode)
      2'd0:    pol = 1'b1;
      2'd1:    pol = 1'b0;
      2'd2:    pol = (pn == 8'd0);
      default: pol = ln[0];
    endcase
    if (zs.z_vld && !m_ack) m_stl = m_stl + 32'd1;
    if (trn) m_trn = m_trn + 32'd1;
    m_ack      = pol && (occ < DEPTH);
    m_cnt      = occ;
    m_lfsr     = ln;
    m_phase    = pn;
    m_mode_q   = cfg_mode;
    m_per_q    = cfg_per;
    m_last_trn = trn;
  endtask

  task automatic checkAll();
    checkOutput("ack", 32'(zs.z_ack), 32'(m_ack));
    checkOutput("r_vld", 32'(r_vld), 32'(m_cnt != 0));
    checkOutput("r_cnt", 32'(r_cnt), m_cnt);
    checkOutput("cnt_trn", cnt_trn, m_trn);
    checkOutput("cnt_stl", cnt_stl, m_stl);
    if (m_cnt != 0 && sb.size() > 0) checkOutput("r_dat", 32'(r_dat), 32'(sb[0]));
  endtask

  // One clock cycle: check outputs at the falling edge, drive inputs, let the rising edge happen, advance the model.
  task automatic applyStimulus(input logic vld, input logic [BW-1:0] bus, input logic rd);
    checkAll();
    zs.z_vld = vld;
    zs.z_bus = vld ? bus : 'x;
    r_rd     = rd;
    @(posedge z_clk);
    modelEdge();
    @(negedge z_clk);
  endtask

  task automatic doReset(input logic [1:0] mode, input logic [7:0] per);
    zs.z_vld = 1'b0;
    r_rd     = 1'b0;
    z_rst    = 1'b1;
    cfg_mode = mode;
    cfg_per  = per;
    modelReset();
    repeat (2) @(negedge z_clk);
    checkOutput("rst_ack", 32'(zs.z_ack), 32'd0);
    checkOutput("rst_r_vld", 32'(r_vld), 32'd0);
    checkOutput("rst_r_cnt", 32'(r_cnt), 32'd0);
    checkOutput("rst_cnt_trn", cnt_trn, 32'd0);
    checkOutput("rst_cnt_stl", cnt_stl, 32'd0);
    z_rst = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] tx [$];
    logic [BW-1:0] exp_order [4];
    int            acks;

    cfg_mode = 2'd0;
    cfg_per  = 8'd0;
    zs.z_vld = 1'b0;
    zs.z_bus = '0;
    r_rd     = 1'b0;

    // Mode 0 fill to full with a fifth word left waiting.
    doReset(2'd0, 8'd0);
    tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, tx[0], 1'b0);
      if (m_last_trn && tx.size() > 1) void'(tx.pop_front());
    end
    checkOutput("fill_r_cnt", 32'(r_cnt), 32'd4);
    checkOutput("fill_ack", 32'(zs.z_ack), 32'd0);
    checkOutput("fill_cnt_trn", cnt_trn, 32'd4);
    checkOutput("fill_cnt_stl", cnt_stl, 32'd4);

    // Single pop frees a slot, the waiting word goes in, order preserved.
    checkOutput("pop_head", 32'(r_dat), 32'h01);
    applyStimulus(1'b1, 8'h05, 1'b1);
    checkOutput("pop_ack_back", 32'(zs.z_ack), 32'd1);
    checkOutput("pop_r_cnt", 32'(r_cnt), 32'd3);
    applyStimulus(1'b1, 8'h05, 1'b0);
    checkOutput("accept5_r_cnt", 32'(r_cnt), 32'd4);
    checkOutput("accept5_cnt_trn", cnt_trn, 32'd5);
    exp_order = '{8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_order", 32'(r_dat), 32'(exp_order[i]));
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("drain_empty", 32'(r_vld), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("empty_pop_cnt", 32'(r_cnt), 32'd0);

    // Mode 1: never acknowledge, every valid cycle is a stall.
    doReset(2'd1, 8'd0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b0);
      if (zs.z_ack) acks++;
    end
    checkOutput("never_acks", 32'(acks), 32'd0);
    checkOutput("never_cnt_trn", cnt_trn, 32'd0);
    checkOutput("never_cnt_stl", cnt_stl, 32'd10);

    // Mode 2, interval 3: one ack in four with continuous valid.
    doReset(2'd2, 8'd3);
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b1);
      if (zs.z_ack) acks++;
    end
    checkOutput("per_acks", 32'(acks), 32'd25);
    checkOutput("per_cnt_trn", cnt_trn, 32'd25);
    cfg_per = 8'd1;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
    cfg_per = 8'd0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
    checkOutput("per0_ack", 32'(zs.z_ack), 32'd1);

    // Mode 3: pseudo-random ack against the reference LFSR, random traffic and pops.
    doReset(2'd3, 8'd0);
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rand_drained", 32'(r_cnt), 32'd0);

    // Reset mid-transfer with three words held, then a fresh capture.
    doReset(2'd0, 8'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
    checkOutput("pre_rst_r_cnt", 32'(r_cnt), 32'd3);
    zs.z_vld = 1'b1;
    zs.z_bus = 8'h77;
    #2 z_rst = 1'b1;
    #1;
    checkOutput("async_rst_ack", 32'(zs.z_ack), 32'd0);
    checkOutput("async_rst_r_vld", 32'(r_vld), 32'd0);
    checkOutput("async_rst_r_cnt", 32'(r_cnt), 32'd0);
    checkOutput("async_rst_cnt_trn", cnt_trn, 32'd0);
    checkOutput("async_rst_cnt_stl", cnt_stl, 32'd0);
    modelReset();
    @(negedge z_clk);
    z_rst = 1'b0;
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("fresh_r_vld", 32'(r_vld), 32'd1);
    checkOutput("fresh_r_cnt", 32'(r_cnt), 32'd1);
    checkOutput("fresh_r_dat", 32'(r_dat), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkAll();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
